// File: rtl/mem_arbiter_pkg.sv
// Shared core package: arbiter state encoding, bus widths, the fixed
// instruction byte-enable mask and the memory request payload.
package mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BEW  = 4;
  localparam int unsigned CNTW = 5;

  // Instruction fetches always read a full word.
  localparam logic [BEW-1:0] I_BE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_I = 2'd1,
    GNT_D = 2'd2
  } state_e;

  // Registered memory-side request payload, latched on grant entry.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BEW-1:0]  be;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Core/memory bus seen by the arbiter.
//   core fetch port : i_req, i_addr -> i_rdata, i_valid
//   core data port  : d_req, d_we, d_addr, d_wdata, d_be -> d_rdata, d_valid
//   memory port     : m_req, m_we, m_addr, m_wdata, m_be <- m_ready, m_rdata
//   status          : stall, err
// modport master: arbiter side; modport slave: core + memory side.
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  logic            i_req;
  logic [XLEN-1:0] i_addr;
  logic [XLEN-1:0] i_rdata;
  logic            i_valid;

  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [BEW-1:0]  d_be;
  logic [XLEN-1:0] d_rdata;
  logic            d_valid;

  logic            m_req;
  logic            m_we;
  logic [XLEN-1:0] m_addr;
  logic [XLEN-1:0] m_wdata;
  logic [BEW-1:0]  m_be;
  logic            m_ready;
  logic [XLEN-1:0] m_rdata;

  logic            stall;
  logic            err;

  modport master (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rdata,
    output i_rdata, i_valid, d_rdata, d_valid,
    output m_req, m_we, m_addr, m_wdata, m_be, stall, err
  );

  modport slave (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_be, m_ready, m_rdata,
    input  i_rdata, i_valid, d_rdata, d_valid,
    input  m_req, m_we, m_addr, m_wdata, m_be, stall, err
  );

endinterface

// File: rtl/mem_arbiter.sv
// Arbiter between the core's fetch and data ports and a single unified
// memory. One request in flight; ports alternate when both are waiting.
// Ports:
//   clk    - clock, all registers on rising edge
//   reset  - synchronous active-low reset
//   bus    - mem_arbiter_if.master (core ports, memory port, stall, err)
// Parameters:
//   DATA_FIRST - tie-break from IDLE: 1 = data port, 0 = fetch port
//   TIMEOUT    - grant cycles without m_ready before the access is aborted
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter bit          DATA_FIRST = 1'b1,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  state_e          state_q, state_d;
  mem_req_t        req_q, req_d;
  logic            m_req_q, m_req_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] i_rdata_q, i_rdata_d;
  logic [XLEN-1:0] d_rdata_q, d_rdata_d;
  logic            i_valid_q, i_valid_d;
  logic            d_valid_q, d_valid_d;
  logic            err_q, err_d;

  logic i_pend, d_pend, tmo, done, go_i, go_d;

  // A port whose valid is pulsing this cycle is already served; its request
  // is still high only because the core has not yet seen the pulse.
  assign i_pend = bus.i_req & ~i_valid_q;
  assign d_pend = bus.d_req & ~d_valid_q;

  assign tmo = (state_q != IDLE) && !bus.m_ready &&
               (cnt_q == CNTW'(TIMEOUT - 1));

  // Next-state, datapath and output register inputs.
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    m_req_d   = m_req_q;
    cnt_d     = cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_valid_d = 1'b0;
    d_valid_d = 1'b0;
    err_d     = err_q;
    done      = 1'b0;
    go_i      = 1'b0;
    go_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_pend && (!i_pend || DATA_FIRST)) go_d = 1'b1;
        else if (i_pend)                       go_i = 1'b1;
      end
      GNT_I: begin
        if (bus.m_ready || tmo) begin
          done      = 1'b1;
          i_valid_d = 1'b1;
          i_rdata_d = bus.m_ready ? bus.m_rdata : '0;
          go_d      = d_pend;
        end
      end
      GNT_D: begin
        if (bus.m_ready || tmo) begin
          done      = 1'b1;
          d_valid_d = 1'b1;
          d_rdata_d = (bus.m_ready && !req_q.we) ? bus.m_rdata : '0;
          go_i      = i_pend;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE && !bus.m_ready) cnt_d = cnt_q + CNTW'(1);
    if (tmo) err_d = 1'b1;

    // Grant entry latches the memory request for the whole grant.
    if (go_d) begin
      state_d = GNT_D;
      m_req_d = 1'b1;
      cnt_d   = '0;
      req_d   = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, be: bus.d_be};
    end else if (go_i) begin
      state_d = GNT_I;
      m_req_d = 1'b1;
      cnt_d   = '0;
      req_d   = '{we: 1'b0, addr: bus.i_addr, wdata: '0, be: I_BE};
    end else if (done) begin
      state_d = IDLE;
      m_req_d = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= '0;
      m_req_q   <= 1'b0;
      cnt_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_valid_q <= 1'b0;
      d_valid_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      m_req_q   <= m_req_d;
      cnt_q     <= cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_valid_q <= i_valid_d;
      d_valid_q <= d_valid_d;
      err_q     <= err_d;
    end
  end

  assign bus.m_req   = m_req_q;
  assign bus.m_we    = req_q.we;
  assign bus.m_addr  = req_q.addr;
  assign bus.m_wdata = req_q.wdata;
  assign bus.m_be    = req_q.be;
  assign bus.i_rdata = i_rdata_q;
  assign bus.i_valid = i_valid_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.d_valid = d_valid_q;
  assign bus.err     = err_q;
  assign bus.stall   = i_pend | d_pend;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand-written
// sequences for timeout, back-pressure and reset during a grant.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam bit H = 1'b1;
  localparam bit L = 1'b0;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(.DATA_FIRST(1'b1), .TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int unsigned errors = 0;
  int unsigned checks = 0;

  // Row inputs are applied for one cycle; expectations are sampled just
  // after the following rising edge (stall uses the same row's inputs).
  typedef struct {
    bit        ir;   bit [31:0] ia;
    bit        dr;   bit        dwe;  bit [31:0] da;  bit [31:0] dwd; bit [3:0] dbe;
    bit        mr;   bit [31:0] mrd;
    bit        e_mreq; bit e_mwe; bit [31:0] e_ma; bit [3:0] e_mbe; bit [31:0] e_mwd;
    bit        e_iv; bit        e_dv; bit [31:0] e_ird; bit [31:0] e_drd;
    bit        e_stall;
  } vec_t;

  vec_t vec [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit ir, input bit [31:0] ia, input bit dr, input bit dwe,
                       input bit [31:0] da, input bit [31:0] dwd, input bit [3:0] dbe,
                       input bit mr, input bit [31:0] mrd);
    bus.i_req   = ir;
    bus.i_addr  = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_addr  = da;
    bus.d_wdata = dwd;
    bus.d_be    = dbe;
    bus.m_ready = mr;
    bus.m_rdata = mrd;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    //        ir ia         dr dwe da          dwd           dbe   mr mrd            mreq mwe ma         mbe   mwd           iv dv ird            drd            stall
    vec[0]  = '{H, 32'h100, L, L, 32'h0,   32'h0,        4'h0, L, 32'h0,         H, L, 32'h100, 4'hF, 32'h0,        L, L, 32'h0,        32'h0,        H};
    vec[1]  = '{H, 32'h100, L, L, 32'h0,   32'h0,        4'h0, L, 32'h0,         H, L, 32'h100, 4'hF, 32'h0,        L, L, 32'h0,        32'h0,        H};
    vec[2]  = '{H, 32'h100, L, L, 32'h0,   32'h0,        4'h0, H, 32'hE3A01005,  L, L, 32'h0,   4'h0, 32'h0,        H, L, 32'hE3A01005, 32'h0,        L};
    vec[3]  = '{L, 32'h0,   L, L, 32'h0,   32'h0,        4'h0, L, 32'h0,         L, L, 32'h0,   4'h0, 32'h0,        L, L, 32'hE3A01005, 32'h0,        L};
    vec[4]  = '{H, 32'h104, H, L, 32'h200, 32'h0,        4'hF, L, 32'h0,         H, L, 32'h200, 4'hF, 32'h0,        L, L, 32'hE3A01005, 32'h0,        H};
    vec[5]  = '{H, 32'h104, H, L, 32'h200, 32'h0,        4'hF, L, 32'h0,         H, L, 32'h200, 4'hF, 32'h0,        L, L, 32'hE3A01005, 32'h0,        H};
    vec[6]  = '{H, 32'h104, H, L, 32'h200, 32'h0,        4'hF, H, 32'hAAAA5555,  H, L, 32'h104, 4'hF, 32'h0,        L, H, 32'hE3A01005, 32'hAAAA5555, H};
    vec[7]  = '{H, 32'h104, L, L, 32'h0,   32'h0,        4'h0, L, 32'h0,         H, L, 32'h104, 4'hF, 32'h0,        L, L, 32'hE3A01005, 32'hAAAA5555, H};
    vec[8]  = '{H, 32'h104, L, L, 32'h0,   32'h0,        4'h0, H, 32'hE59F0010,  L, L, 32'h0,   4'h0, 32'h0,        H, L, 32'hE59F0010, 32'hAAAA5555, L};
    vec[9]  = '{L, 32'h0,   L, L, 32'h0,   32'h0,        4'h0, L, 32'h0,         L, L, 32'h0,   4'h0, 32'h0,        L, L, 32'hE59F0010, 32'hAAAA5555, L};
    vec[10] = '{L, 32'h0,   H, H, 32'h40,  32'h12345678, 4'h3, L, 32'h0,         H, H, 32'h40,  4'h3, 32'h12345678, L, L, 32'hE59F0010, 32'hAAAA5555, H};
    vec[11] = '{L, 32'h0,   H, H, 32'h40,  32'h12345678, 4'h3, L, 32'h0,         H, H, 32'h40,  4'h3, 32'h12345678, L, L, 32'hE59F0010, 32'hAAAA5555, H};
    vec[12] = '{L, 32'h0,   H, H, 32'h40,  32'h12345678, 4'h3, H, 32'hDEADBEEF,  L, L, 32'h0,   4'h0, 32'h0,        L, H, 32'hE59F0010, 32'h0,        L};
    vec[13] = '{L, 32'h0,   H, H, 32'h40,  32'h12345678, 4'h3, L, 32'h0,         L, L, 32'h0,   4'h0, 32'h0,        L, L, 32'hE59F0010, 32'h0,        H};
    vec[14] = '{L, 32'h0,   L, L, 32'h0,   32'h0,        4'h0, H, 32'hFFFFFFFF,  L, L, 32'h0,   4'h0, 32'h0,        L, L, 32'hE59F0010, 32'h0,        L};
    vec[15] = '{L, 32'h0,   H, L, 32'h600, 32'h0,        4'hF, L, 32'h0,         H, L, 32'h600, 4'hF, 32'h0,        L, L, 32'hE59F0010, 32'h0,        H};
    vec[16] = '{L, 32'h0,   H, L, 32'h600, 32'h0,        4'hF, L, 32'h0,         H, L, 32'h600, 4'hF, 32'h0,        L, L, 32'hE59F0010, 32'h0,        H};
    vec[17] = '{L, 32'h0,   H, L, 32'h600, 32'h0,        4'hF, H, 32'h5A5A5A5A,  L, L, 32'h0,   4'h0, 32'h0,        L, H, 32'hE59F0010, 32'h5A5A5A5A, L};
    vec[18] = '{L, 32'h0,   L, L, 32'h0,   32'h0,        4'h0, L, 32'h0,         L, L, 32'h0,   4'h0, 32'h0,        L, L, 32'hE59F0010, 32'h5A5A5A5A, L};

    // Reset state
    reset = 1'b0;
    drive(L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0);
    tick();
    tick();
    check("reset m_req",   32'(bus.m_req),   32'h0);
    check("reset i_valid", 32'(bus.i_valid), 32'h0);
    check("reset d_valid", 32'(bus.d_valid), 32'h0);
    check("reset err",     32'(bus.err),     32'h0);
    check("reset i_rdata", bus.i_rdata,      32'h0);
    check("reset d_rdata", bus.d_rdata,      32'h0);
    check("reset stall",   32'(bus.stall),   32'h0);
    reset = 1'b1;

    // Fetch, simultaneous load+fetch, store, regrant mask, idle m_ready, load
    for (int k = 0; k < 19; k++) begin
      drive(vec[k].ir, vec[k].ia, vec[k].dr, vec[k].dwe, vec[k].da, vec[k].dwd,
            vec[k].dbe, vec[k].mr, vec[k].mrd);
      tick();
      check($sformatf("row%0d m_req", k),   32'(bus.m_req),   32'(vec[k].e_mreq));
      if (vec[k].e_mreq) begin
        check($sformatf("row%0d m_we", k),    32'(bus.m_we),    32'(vec[k].e_mwe));
        check($sformatf("row%0d m_addr", k),  bus.m_addr,       vec[k].e_ma);
        check($sformatf("row%0d m_be", k),    32'(bus.m_be),    32'(vec[k].e_mbe));
        check($sformatf("row%0d m_wdata", k), bus.m_wdata,      vec[k].e_mwd);
      end
      check($sformatf("row%0d i_valid", k), 32'(bus.i_valid), 32'(vec[k].e_iv));
      check($sformatf("row%0d d_valid", k), 32'(bus.d_valid), 32'(vec[k].e_dv));
      check($sformatf("row%0d i_rdata", k), bus.i_rdata,      vec[k].e_ird);
      check($sformatf("row%0d d_rdata", k), bus.d_rdata,      vec[k].e_drd);
      check($sformatf("row%0d stall", k),   32'(bus.stall),   32'(vec[k].e_stall));
      check($sformatf("row%0d err", k),     32'(bus.err),     32'h0);
    end

    // Timeout: memory never answers a load
    drive(L, 32'h0, H, L, 32'h500, 32'h0, 4'hF, L, 32'h0);
    tick();
    check("tmo grant m_req", 32'(bus.m_req), 32'h1);
    check("tmo grant addr",  bus.m_addr,     32'h500);
    t = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (n == 15) check("tmo err before abort", 32'(bus.err), 32'h0);
      if (bus.d_valid) begin
        t = n;
        break;
      end
    end
    check("tmo cycles to d_valid", 32'(t),         32'd16);
    check("tmo err set",           32'(bus.err),   32'h1);
    check("tmo d_rdata zero",      bus.d_rdata,    32'h0);
    check("tmo m_req dropped",     32'(bus.m_req), 32'h0);
    drive(L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0);
    tick();
    check("tmo err sticky",  32'(bus.err),     32'h1);
    check("tmo single pulse", 32'(bus.d_valid), 32'h0);

    // Back-pressure: m_ready arrives on the sixth grant cycle
    drive(H, 32'h300, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0);
    tick();
    for (int j = 0; j < 5; j++) begin
      check($sformatf("bp%0d m_req", j),   32'(bus.m_req),   32'h1);
      check($sformatf("bp%0d m_addr", j),  bus.m_addr,       32'h300);
      check($sformatf("bp%0d stall", j),   32'(bus.stall),   32'h1);
      check($sformatf("bp%0d i_valid", j), 32'(bus.i_valid), 32'h0);
      tick();
    end
    drive(H, 32'h300, L, L, 32'h0, 32'h0, 4'h0, H, 32'h11223344);
    check("bp ready cycle stall", 32'(bus.stall), 32'h1);
    check("bp ready cycle addr",  bus.m_addr,     32'h300);
    tick();
    check("bp i_valid at grant+6", 32'(bus.i_valid), 32'h1);
    check("bp i_rdata",            bus.i_rdata,      32'h11223344);
    check("bp stall released",     32'(bus.stall),   32'h0);
    drive(L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, L, 32'h0);
    tick();
    check("bp i_valid one pulse", 32'(bus.i_valid), 32'h0);

    // Reset during a data grant
    drive(L, 32'h0, H, L, 32'h700, 32'h0, 4'hF, L, 32'h0);
    tick();
    check("rst grant m_req", 32'(bus.m_req), 32'h1);
    reset = 1'b0;
    tick();
    check("rst m_req",   32'(bus.m_req),   32'h0);
    check("rst d_valid", 32'(bus.d_valid), 32'h0);
    check("rst err",     32'(bus.err),     32'h0);
    check("rst i_rdata", bus.i_rdata,      32'h0);
    check("rst m_addr",  bus.m_addr,       32'h0);
    reset = 1'b1;
    drive(L, 32'h0, L, L, 32'h0, 32'h0, 4'h0, H, 32'hCAFEF00D);
    tick();
    check("rst idle no d_valid", 32'(bus.d_valid), 32'h0);
    check("rst idle m_req",      32'(bus.m_req),   32'h0);
    check("rst idle d_rdata",    bus.d_rdata,      32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
